wb_port_arbiter: RTL and testbench

- Arbitrates the single register-file write port between two sources.
- Source 1 is the in-order core writeback: Result from the result select, with the core's RegWrite and Rd.
- Source 2 is a long-latency execution unit (iterative mul/div) that completes out of order.
- Holds a per-register pending scoreboard, a one-entry result buffer and an anti-starvation counter. Drives the core Stall on hazards.

---
 rtl/wb_port_arbiter_pkg.sv | 18 +
 rtl/wb_scoreboard.sv | 45 ++++
 rtl/wb_port_arbiter.sv | 115 +++++++++++
 tb/tb_wb_port_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
package wb_port_arbiter_pkg;

  localparam int REG_AW       = 5;
  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_HOLD  = 2'd1,
    WB_FORCE = 2'd2
  } wb_state_t;

  // One-hot mask for a register address (bit 0 is x0).
  function automatic logic [31:0] reg_onehot(input logic [REG_AW-1:0] rd);
    return 32'd1 << rd;
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register pending scoreboard: one bit per architectural register that
// has an outstanding long-latency result. x0 is never pending.
module wb_scoreboard
  import wb_port_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_rd,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_rd,
  input  logic [REG_AW-1:0] look_a,
  input  logic [REG_AW-1:0] look_b,
  input  logic [REG_AW-1:0] look_c,
  input  logic [REG_AW-1:0] look_d,
  output logic              hit_a,
  output logic              hit_b,
  output logic              hit_c,
  output logic              hit_d
);

  logic [31:0] pending;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;

  assign set_mask = set_en ? reg_onehot(set_rd) : 32'd0;
  assign clr_mask = clr_en ? reg_onehot(clr_rd) : 32'd0;

  // Pending bits: clear on buffer commit, set on accepted issue; bit 0 pinned low.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    if (reset) begin
      pending <= 32'd0;
    end else begin
      pending <= ((pending & ~clr_mask) | set_mask) & ~32'd1;
    end
  end

  assign hit_a = pending[look_a];
  assign hit_b = pending[look_b];
  assign hit_c = pending[look_c];
  assign hit_d = pending[look_d];

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between in-order core writeback and an
// out-of-order long-latency unit, with a one-entry result buffer and an
// anti-starvation counter that eventually stalls the core.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CoreWE,
  input  logic [REG_AW-1:0] CoreRd,
  input  logic [XLEN-1:0]   CoreResult,
  input  logic [REG_AW-1:0] Rs1,
  input  logic [REG_AW-1:0] Rs2,
  input  logic              LLIssue,
  input  logic [REG_AW-1:0] LLIssueRd,
  output logic              LLIssueOK,
  input  logic              LLValid,
  input  logic [REG_AW-1:0] LLRd,
  input  logic [XLEN-1:0]   LLData,
  output logic              LLReady,
  output logic              RegWrite,
  output logic [REG_AW-1:0] WriteAddr,
  output logic [XLEN-1:0]   WriteData,
  output logic              Stall
);

  localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  wb_state_t         state;
  logic [REG_AW-1:0] buf_rd;
  logic [XLEN-1:0]   buf_data;
  logic [WAIT_W-1:0] wait_cnt;

  logic pend_rs1, pend_rs2, pend_core, pend_issue;
  logic hz, issue_blk, core_go, buf_wr, issue_set;

  wb_scoreboard u_scoreboard (
    .clk    (clk),
    .reset  (reset),
    .set_en (issue_set),
    .set_rd (LLIssueRd),
    .clr_en (buf_wr),
    .clr_rd (buf_rd),
    .look_a (Rs1),
    .look_b (Rs2),
    .look_c (CoreRd),
    .look_d (LLIssueRd),
    .hit_a  (pend_rs1),
    .hit_b  (pend_rs2),
    .hit_c  (pend_core),
    .hit_d  (pend_issue)
  );

  assign hz        = pend_rs1 | pend_rs2 | (CoreWE & pend_core);
  assign issue_blk = LLIssue & pend_issue;
  assign Stall     = hz | issue_blk | (state == WB_FORCE);
  assign core_go   = CoreWE & ~Stall & (CoreRd != '0);
  assign LLIssueOK = LLIssue & ~Stall;
  assign issue_set = LLIssueOK & (LLIssueRd != '0);
  assign LLReady   = (state == WB_IDLE);
  assign buf_wr    = (state == WB_FORCE) | ((state == WB_HOLD) & ~core_go);

  // Write-port mux: buffer when it must or may drain, otherwise the core.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    RegWrite  = 1'b0;
    WriteAddr = CoreRd;
    WriteData = CoreResult;
    if (buf_wr) begin
      RegWrite  = 1'b1;
      WriteAddr = buf_rd;
      WriteData = buf_data;
    end else if (core_go) begin
      RegWrite  = 1'b1;
    end
  end

  // Arbitration FSM with result buffer and starvation counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= WB_IDLE;
      buf_rd   <= '0;
      buf_data <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        WB_IDLE: begin
          if (LLValid) begin
            buf_rd   <= LLRd;
            buf_data <= LLData;
            wait_cnt <= '0;
            // A result for x0 is accepted and dropped.
            if (LLRd != '0) state <= WB_HOLD;
          end
        end
        WB_HOLD: begin
          if (!core_go) begin
            state <= WB_IDLE;
          end else if (wait_cnt == WAIT_W'(MAX_WAIT)) begin
            state <= WB_FORCE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        WB_FORCE: state <= WB_IDLE;
        default:  state <= WB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: a per-cycle reference model plus
// directed vectors with hand-computed expectations.
module tb_wb_port_arbiter;

  localparam int XLEN     = 32;
  localparam int MAX_WAIT = 4;

  logic            clk;
  logic            reset;
  logic            CoreWE;
  logic [4:0]      CoreRd;
  logic [XLEN-1:0] CoreResult;
  logic [4:0]      Rs1, Rs2;
  logic            LLIssue;
  logic [4:0]      LLIssueRd;
  logic            LLIssueOK;
  logic            LLValid;
  logic [4:0]      LLRd;
  logic [XLEN-1:0] LLData;
  logic            LLReady;
  logic            RegWrite;
  logic [4:0]      WriteAddr;
  logic [XLEN-1:0] WriteData;
  logic            Stall;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  wb_port_arbiter #(.XLEN(XLEN), .MAX_WAIT(MAX_WAIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .CoreWE     (CoreWE),
    .CoreRd     (CoreRd),
    .CoreResult (CoreResult),
    .Rs1        (Rs1),
    .Rs2        (Rs2),
    .LLIssue    (LLIssue),
    .LLIssueRd  (LLIssueRd),
    .LLIssueOK  (LLIssueOK),
    .LLValid    (LLValid),
    .LLRd       (LLRd),
    .LLData     (LLData),
    .LLReady    (LLReady),
    .RegWrite   (RegWrite),
    .WriteAddr  (WriteAddr),
    .WriteData  (WriteData),
    .Stall      (Stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Outstanding registers, an optional buffered result, how many times it has
  // lost to the core, and whether it must be written now.
  bit [31:0]       m_pending;
  bit              m_has_buf;
  bit [4:0]        m_buf_rd;
  bit [XLEN-1:0]   m_buf_data;
  int              m_losses;
  bit              m_force;

  typedef struct packed {
    logic            stall;
    logic            ok;
    logic            ready;
    logic            we;
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
    logic            core_go;
    logic            buf_wr;
  } exp_t;

  function automatic bit pend(input logic [4:0] r);
    return (r == 5'd0) ? 1'b0 : m_pending[r];
  endfunction

  function automatic exp_t model_eval();
    exp_t e;
    e.stall   = pend(Rs1) | pend(Rs2) | (CoreWE & pend(CoreRd)) |
                (LLIssue & pend(LLIssueRd)) | m_force;
    e.core_go = CoreWE & ~e.stall & (CoreRd != 5'd0);
    e.ok      = LLIssue & ~e.stall;
    e.ready   = ~m_has_buf;
    e.buf_wr  = m_has_buf & (m_force | ~e.core_go);
    e.we      = e.buf_wr | e.core_go;
    e.addr    = e.buf_wr ? m_buf_rd : CoreRd;
    e.data    = e.buf_wr ? m_buf_data : CoreResult;
    return e;
  endfunction

  // Model state advance on each rising edge.
  always @(posedge clk) begin
    exp_t          e;
    bit [31:0]     np;
    bit            nh, nf;
    bit [4:0]      nrd;
    bit [XLEN-1:0] nd;
    int            nl;
    e = model_eval();
    np = m_pending; nh = m_has_buf; nf = m_force; nrd = m_buf_rd; nd = m_buf_data; nl = m_losses;
    if (reset) begin
      np = '0; nh = 0; nf = 0; nrd = '0; nd = '0; nl = 0;
    end else begin
      if (e.buf_wr) begin
        np[m_buf_rd] = 1'b0;
        nh = 0;
        nf = 0;
      end
      if (e.core_go && m_has_buf && !m_force) begin
        if (m_losses == MAX_WAIT) nf = 1;
        else nl = m_losses + 1;
      end
      if (e.ok && LLIssueRd != 5'd0) np[LLIssueRd] = 1'b1;
      if (e.ready && LLValid && LLRd != 5'd0) begin
        nh = 1; nrd = LLRd; nd = LLData; nl = 0;
      end
    end
    m_pending  <= np;
    m_has_buf  <= nh;
    m_force    <= nf;
    m_buf_rd   <= nrd;
    m_buf_data <= nd;
    m_losses   <= nl;
  end

  // Compare process: mid-cycle, all outputs against the model.
  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      e = model_eval();
      check("model_stall",    Stall,     e.stall);
      check("model_issue_ok", LLIssueOK, e.ok);
      check("model_ll_ready", LLReady,   e.ready);
      check("model_regwrite", RegWrite,  e.we);
      if (e.we) begin
        check("model_waddr", WriteAddr, e.addr);
        check("model_wdata", WriteData, e.data);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    CoreWE = 0; CoreRd = 0; CoreResult = 0;
    Rs1 = 0; Rs2 = 0;
    LLIssue = 0; LLIssueRd = 0;
    LLValid = 0; LLRd = 0; LLData = 0;
  endtask

  initial begin
    idle();
    reset = 1;
    cyc();
    cyc();
    reset = 0;
    chk_en = 1;

    // Reset state
    #4;
    check("rst_regwrite", RegWrite, 0);
    check("rst_stall", Stall, 0);
    check("rst_ll_ready", LLReady, 1);
    cyc();

    // Plain core write
    CoreWE = 1; CoreRd = 5; CoreResult = 32'h1234;
    #4;
    check("core_we", RegWrite, 1);
    check("core_addr", WriteAddr, 5);
    check("core_data", WriteData, 32'h1234);
    cyc();

    // Basic long-latency path
    idle(); LLIssue = 1; LLIssueRd = 7;
    #4; check("issue7_ok", LLIssueOK, 1); check("issue7_stall", Stall, 0);
    cyc();
    idle(); Rs1 = 7;
    #4; check("raw7_stall", Stall, 1);
    cyc();
    idle(); LLValid = 1; LLRd = 7; LLData = 32'hDEAD;
    #4; check("acc7_ready", LLReady, 1); check("acc7_nowrite", RegWrite, 0);
    cyc();
    idle();
    #4;
    check("drain7_we", RegWrite, 1);
    check("drain7_addr", WriteAddr, 7);
    check("drain7_data", WriteData, 32'hDEAD);
    check("drain7_ready", LLReady, 0);
    cyc();
    idle(); Rs1 = 7;
    #4; check("after7_stall", Stall, 0); check("after7_ready", LLReady, 1);
    cyc();

    // Starvation: core writes x3 every cycle while x9 sits in the buffer
    idle(); CoreWE = 1; CoreRd = 3; CoreResult = 32'h33;
    LLValid = 1; LLRd = 9; LLData = 32'h9999;
    #4; check("starve_acc_addr", WriteAddr, 3); check("starve_acc_we", RegWrite, 1);
    cyc();
    LLValid = 0;
    for (int i = 0; i < 5; i++) begin
      #4;
      check("starve_hold_addr", WriteAddr, 3);
      check("starve_hold_stall", Stall, 0);
      check("starve_hold_ready", LLReady, 0);
      cyc();
    end
    #4;
    check("force_stall", Stall, 1);
    check("force_we", RegWrite, 1);
    check("force_addr", WriteAddr, 9);
    check("force_data", WriteData, 32'h9999);
    cyc();
    #4; check("post_force_ready", LLReady, 1); check("post_force_addr", WriteAddr, 3);
    cyc();

    // Hazards and x0
    idle(); LLIssue = 1; LLIssueRd = 7;
    cyc();
    #4; check("reissue7_ok", LLIssueOK, 0); check("reissue7_stall", Stall, 1);
    cyc();
    idle(); LLValid = 1; LLRd = 0; LLData = 32'hBAD;
    #4; check("x0_acc_we", RegWrite, 0);
    cyc();
    idle();
    #4; check("x0_ready", LLReady, 1); check("x0_nowrite", RegWrite, 0);
    cyc();
    CoreWE = 1; CoreRd = 0; CoreResult = 32'h55;
    #4; check("core_x0_we", RegWrite, 0);
    cyc();

    // Commit/issue collision on x7
    idle(); LLValid = 1; LLRd = 7; LLData = 32'h7777;
    cyc();
    idle(); LLIssue = 1; LLIssueRd = 7;
    #4;
    check("coll_we", RegWrite, 1);
    check("coll_addr", WriteAddr, 7);
    check("coll_data", WriteData, 32'h7777);
    check("coll_blocked", LLIssueOK, 0);
    cyc();
    #4; check("coll_retry_ok", LLIssueOK, 1);
    cyc();
    // Commit x7 while issuing x12: both take effect
    idle(); LLValid = 1; LLRd = 7; LLData = 32'h1111;
    cyc();
    idle(); LLIssue = 1; LLIssueRd = 12;
    #4; check("diff_ok", LLIssueOK, 1); check("diff_addr", WriteAddr, 7);
    cyc();
    idle(); Rs1 = 7;
    #4; check("diff_clr7", Stall, 0);
    cyc();
    idle(); Rs2 = 12;
    #4; check("diff_set12", Stall, 1);
    cyc();

    // Reset while holding a buffered result
    idle(); LLValid = 1; LLRd = 9; LLData = 32'hAAAA;
    cyc();
    idle(); reset = 1; CoreWE = 1; CoreRd = 3; CoreResult = 32'h3;
    #4; check("rst_hold_addr", WriteAddr, 3);
    cyc();
    reset = 0; idle(); Rs2 = 12;
    #4;
    check("rst_clr_stall", Stall, 0);
    check("rst_clr_ready", LLReady, 1);
    check("rst_clr_we", RegWrite, 0);
    cyc();
    idle();
    #4; check("rst_no_drain", RegWrite, 0);
    cyc();

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
